// File: rtl/implication_monitor_if.sv
// Bundle of stimulus and result signals for implication_monitor.
// The master side drives the observed signals and reads the verdicts. The slave side is the monitor.
interface implication_monitor_if #(
  parameter int NUM_PROPS = 2,
  parameter int CNT_WIDTH = 8,
  parameter int CYC_WIDTH = 16
);
  localparam int ID_W = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1;

  logic                 enable;
  logic                 clear;
  logic [NUM_PROPS-1:0] ante;
  logic [NUM_PROPS-1:0] cons;
  logic [NUM_PROPS-1:0] fail_pulse;
  logic                 fail_sticky;
  logic [CNT_WIDTH-1:0] fail_count;
  logic [ID_W-1:0]      first_fail_id;
  logic [CYC_WIDTH-1:0] first_fail_cycle;
  logic [CYC_WIDTH-1:0] cycle_count;

  modport master (
    output enable, clear, ante, cons,
    input  fail_pulse, fail_sticky, fail_count, first_fail_id, first_fail_cycle, cycle_count
  );

  modport slave (
    input  enable, clear, ante, cons,
    output fail_pulse, fail_sticky, fail_count, first_fail_id, first_fail_cycle, cycle_count
  );
endinterface

// File: rtl/implication_monitor.sv
// Hardware checker for "ante[p] |-> ##DELAY cons[p]".
// It keeps one pending pipe per property and shares the violation counter and first-failure capture.
module implication_monitor_lane #(
  parameter int DELAY = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  input  logic ante,
  input  logic cons,
  output logic viol
);
  logic [DELAY-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = '0;
    if (!clear) begin
      pend_d[0] = ante & enable;
      for (int i = 1; i < DELAY; i++) pend_d[i] = pend_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // cons is checked regardless of enable, so checks already in flight always complete
  assign viol = pend_q[DELAY-1] & ~cons;
endmodule

module implication_monitor #(
  parameter int NUM_PROPS = 2,
  parameter int DELAY     = 1,
  parameter int CNT_WIDTH = 8,
  parameter int CYC_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  implication_monitor_if.slave  mon
);
  localparam int ID_W  = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1;
  localparam int SUM_W = CNT_WIDTH + $clog2(NUM_PROPS) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

  logic                 clear_w, enable_w;
  logic [NUM_PROPS-1:0] ante_w, cons_w, viol;

  assign clear_w  = mon.clear;
  assign enable_w = mon.enable;
  assign ante_w   = mon.ante;
  assign cons_w   = mon.cons;

  implication_monitor_lane #(.DELAY(DELAY)) u_lane [NUM_PROPS-1:0] (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (clear_w),
    .enable (enable_w),
    .ante   (ante_w),
    .cons   (cons_w),
    .viol   (viol)
  );

  logic [NUM_PROPS-1:0] fail_pulse_q, fail_pulse_d;
  logic                 fail_sticky_q, fail_sticky_d;
  logic [CNT_WIDTH-1:0] fail_count_q, fail_count_d;
  logic [ID_W-1:0]      first_fail_id_q, first_fail_id_d;
  logic [CYC_WIDTH-1:0] first_fail_cycle_q, first_fail_cycle_d;
  logic [CYC_WIDTH-1:0] cycle_count_q, cycle_count_d;

  logic [SUM_W-1:0]     viol_pop, count_sum;
  logic [ID_W-1:0]      low_id;

  always_comb begin
    viol_pop = '0;
    low_id   = '0;
    for (int i = 0; i < NUM_PROPS; i++) viol_pop = viol_pop + SUM_W'(viol[i]);
    // Descending scan leaves the lowest set index in low_id
    for (int i = NUM_PROPS - 1; i >= 0; i--) if (viol[i]) low_id = ID_W'(i);
    count_sum = {{(SUM_W-CNT_WIDTH){1'b0}}, fail_count_q} + viol_pop;
  end

  always_comb begin
    fail_pulse_d       = viol;
    fail_count_d       = (count_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : count_sum[CNT_WIDTH-1:0];
    fail_sticky_d      = fail_sticky_q;
    first_fail_id_d    = first_fail_id_q;
    first_fail_cycle_d = first_fail_cycle_q;
    cycle_count_d      = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CYC_WIDTH'(1);
    if (|viol && !fail_sticky_q) begin
      fail_sticky_d      = 1'b1;
      first_fail_id_d    = low_id;
      first_fail_cycle_d = cycle_count_q;
    end
    // Soft clear acts exactly like reset, and it drops any violation checked in the same cycle
    if (clear_w) begin
      fail_pulse_d       = '0;
      fail_count_d       = '0;
      fail_sticky_d      = 1'b0;
      first_fail_id_d    = '0;
      first_fail_cycle_d = '0;
      cycle_count_d      = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fail_pulse_q       <= '0;
      fail_count_q       <= '0;
      fail_sticky_q      <= 1'b0;
      first_fail_id_q    <= '0;
      first_fail_cycle_q <= '0;
      cycle_count_q      <= '0;
    end else begin
      fail_pulse_q       <= fail_pulse_d;
      fail_count_q       <= fail_count_d;
      fail_sticky_q      <= fail_sticky_d;
      first_fail_id_q    <= first_fail_id_d;
      first_fail_cycle_q <= first_fail_cycle_d;
      cycle_count_q      <= cycle_count_d;
    end
  end

  assign mon.fail_pulse       = fail_pulse_q;
  assign mon.fail_sticky      = fail_sticky_q;
  assign mon.fail_count       = fail_count_q;
  assign mon.first_fail_id    = first_fail_id_q;
  assign mon.first_fail_cycle = first_fail_cycle_q;
  assign mon.cycle_count      = cycle_count_q;
endmodule

// File: tb/tb_implication_monitor.sv
// Two monitors receive the same stimulus: A has DELAY=1 and CNT_WIDTH=8, B has DELAY=3 and CNT_WIDTH=2.
// Each is compared against a history-based reference model.
module tb_implication_monitor;
  localparam int NP = 2;
  localparam int YW = 16;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  implication_monitor_if #(.NUM_PROPS(NP), .CNT_WIDTH(8), .CYC_WIDTH(YW)) if_a ();
  implication_monitor_if #(.NUM_PROPS(NP), .CNT_WIDTH(2), .CYC_WIDTH(YW)) if_b ();

  implication_monitor #(.NUM_PROPS(NP), .DELAY(1), .CNT_WIDTH(8), .CYC_WIDTH(YW)) dut_a (
    .CLK(CLK), .RESET(RESET), .mon(if_a));
  implication_monitor #(.NUM_PROPS(NP), .DELAY(3), .CNT_WIDTH(2), .CYC_WIDTH(YW)) dut_b (
    .CLK(CLK), .RESET(RESET), .mon(if_b));

  int vectors = 0;
  int miscompares = 0;

  // Per-cycle input history indexed by the absolute step number
  logic [1:0] a_h [4096];
  logic [1:0] c_h [4096];
  bit         rc_h[4096];
  int         n = 0;

  int         dly [2] = '{1, 3};
  int         cmax[2] = '{255, 3};
  logic [1:0] m_pulse[2];
  int         m_cnt[2], m_id[2], m_fc[2], m_cyc[2];
  bit         m_st[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @step %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // A check at cycle t fires when the antecedent was seen at t-d and no reset or clear happened in between
  function automatic logic [1:0] exp_v(int d, int t);
    if (t < d) return 2'b00;
    for (int k = t - d; k < t; k++) if (rc_h[k]) return 2'b00;
    return a_h[t-d] & ~c_h[t];
  endfunction

  task automatic model_edge(int t);
    for (int k = 0; k < 2; k++) begin
      if (rc_h[t]) begin
        m_pulse[k] = 0; m_cnt[k] = 0; m_st[k] = 0; m_id[k] = 0; m_fc[k] = 0; m_cyc[k] = 0;
      end else begin
        logic [1:0] v;
        v = exp_v(dly[k], t);
        m_pulse[k] = v;
        m_cnt[k] = m_cnt[k] + int'(v[0]) + int'(v[1]);
        if (m_cnt[k] > cmax[k]) m_cnt[k] = cmax[k];
        if (v != 0 && !m_st[k]) begin
          m_st[k] = 1; m_id[k] = v[0] ? 0 : 1; m_fc[k] = m_cyc[k];
        end
        if (m_cyc[k] < 65535) m_cyc[k]++;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_pulse",  32'(if_a.fail_pulse),       32'(m_pulse[0]));
    chk("a_sticky", 32'(if_a.fail_sticky),      32'(m_st[0]));
    chk("a_count",  32'(if_a.fail_count),       32'(m_cnt[0]));
    chk("a_id",     32'(if_a.first_fail_id),    32'(m_id[0]));
    chk("a_fcyc",   32'(if_a.first_fail_cycle), 32'(m_fc[0]));
    chk("a_cyc",    32'(if_a.cycle_count),      32'(m_cyc[0]));
    chk("b_pulse",  32'(if_b.fail_pulse),       32'(m_pulse[1]));
    chk("b_sticky", 32'(if_b.fail_sticky),      32'(m_st[1]));
    chk("b_count",  32'(if_b.fail_count),       32'(m_cnt[1]));
    chk("b_id",     32'(if_b.first_fail_id),    32'(m_id[1]));
    chk("b_fcyc",   32'(if_b.first_fail_cycle), 32'(m_fc[1]));
    chk("b_cyc",    32'(if_b.cycle_count),      32'(m_cyc[1]));
  endtask

  task automatic step(input logic [1:0] an, input logic [1:0] cs, input bit en, input bit clr, input bit rst);
    if_a.ante = an; if_a.cons = cs; if_a.enable = en; if_a.clear = clr;
    if_b.ante = an; if_b.cons = cs; if_b.enable = en; if_b.clear = clr;
    RESET = rst;
    a_h[n] = en ? an : 2'b00; c_h[n] = cs; rc_h[n] = rst | clr;
    @(posedge CLK);
    model_edge(n);
    #1;
    n++;
    compare_all();
  endtask

  initial begin
    static int sat_seq[5] = '{1, 2, 3, 3, 3};
    // Reset: hold for three cycles, then count up from 0
    repeat (3) step(2'b00, 2'b11, 1, 0, 1);
    chk("rst_pulse", 32'(if_a.fail_pulse), 0);
    chk("rst_count", 32'(if_a.fail_count), 0);
    chk("rst_cyc0",  32'(if_a.cycle_count), 0);
    step(2'b00, 2'b11, 1, 0, 0); chk("cyc1", 32'(if_a.cycle_count), 1);
    step(2'b00, 2'b11, 1, 0, 0); chk("cyc2", 32'(if_a.cycle_count), 2);
    step(2'b00, 2'b11, 1, 0, 0);
    // Pass case
    step(2'b01, 2'b11, 1, 0, 0);
    step(2'b00, 2'b01, 1, 0, 0);
    chk("pass_pulse",  32'(if_a.fail_pulse), 0);
    chk("pass_sticky", 32'(if_a.fail_sticky), 0);
    // Single violation
    step(2'b01, 2'b11, 1, 0, 0);
    step(2'b00, 2'b00, 1, 0, 0);
    chk("viol_pulse", 32'(if_a.fail_pulse), 1);
    chk("viol_count", 32'(if_a.fail_count), 1);
    chk("viol_id",    32'(if_a.first_fail_id), 0);
    chk("viol_fcyc",  32'(if_a.first_fail_cycle), 6);
    // Simultaneous violations after a clear
    step(2'b00, 2'b11, 1, 1, 0);
    step(2'b00, 2'b11, 1, 0, 0);
    step(2'b00, 2'b11, 1, 0, 0);
    step(2'b11, 2'b11, 1, 0, 0);
    step(2'b00, 2'b00, 1, 0, 0);
    chk("sim_pulse", 32'(if_a.fail_pulse), 3);
    chk("sim_count", 32'(if_a.fail_count), 2);
    chk("sim_fcyc",  32'(if_a.first_fail_cycle), 3);
    step(2'b10, 2'b11, 1, 0, 0);
    step(2'b00, 2'b00, 1, 0, 0);
    chk("sim_count3", 32'(if_a.fail_count), 3);
    chk("sim_id",     32'(if_a.first_fail_id), 0);
    // Saturation on B (CNT_WIDTH=2); early cons=0 must not flag with DELAY=3
    step(2'b00, 2'b11, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(2'b01, 2'b11, 1, 0, 0);
      step(2'b00, 2'b00, 1, 0, 0); chk("dly_early1", 32'(if_b.fail_pulse), 0);
      step(2'b00, 2'b00, 1, 0, 0); chk("dly_early2", 32'(if_b.fail_pulse), 0);
      step(2'b00, 2'b00, 1, 0, 0); chk("dly_pulse",  32'(if_b.fail_pulse), 1);
      chk("sat_count", 32'(if_b.fail_count), 32'(sat_seq[i]));
    end
    // A clear in the same cycle as a violating check discards the violation
    step(2'b00, 2'b11, 1, 1, 0);
    step(2'b01, 2'b11, 1, 0, 0);
    step(2'b00, 2'b00, 1, 1, 0);
    chk("clr_pulse",  32'(if_a.fail_pulse), 0);
    chk("clr_count",  32'(if_a.fail_count), 0);
    chk("clr_sticky", 32'(if_a.fail_sticky), 0);
    // A reset mid-flight drops the pending antecedent
    step(2'b01, 2'b11, 1, 0, 0);
    step(2'b00, 2'b00, 1, 0, 1);
    repeat (5) begin
      step(2'b00, 2'b00, 1, 0, 0);
      chk("rstmid_pulse", 32'(if_b.fail_pulse), 0);
    end
    // Antecedents seen while enable=0 are never checked
    step(2'b11, 2'b00, 0, 0, 0);
    repeat (5) begin
      step(2'b00, 2'b00, 1, 0, 0);
      chk("en0_pulse_a", 32'(if_a.fail_pulse), 0);
      chk("en0_pulse_b", 32'(if_b.fail_pulse), 0);
    end
    // Randomized traffic, checked against the model
    repeat (600) begin
      logic [1:0] an, cs;
      an = 2'($urandom_range(0, 3));
      cs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      step(an, cs, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/implication_monitor.md
Name: implication_monitor

Overview:
- Synthesizable, cycle-accurate checker for properties of the form "ante[p] |-> ##DELAY cons[p]".
- Sits directly downstream of the register stage under test. It consumes that stage's input and registered output, plus any auxiliary input pairs such as arr[0]/arr[1].
- Counts and reports violations in hardware, so the same implications hold on FPGA and in emulation, where inline SVA is unavailable.

Parameters:
NUM_PROPS, 2, number of independent implication properties checked in parallel
DELAY, 1, cycles between antecedent sample and consequent check (legal range 1..8)
CNT_WIDTH, 8, width of the saturating violation counter
CYC_WIDTH, 16, width of the saturating cycle counter and the first-failure timestamp

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  synchronous, active-high reset
enable  input  1  when 1, antecedents are sampled; when 0, zeros are shifted in
clear  input  1  synchronous soft clear; same effect as RESET on state, lower priority
ante  input  NUM_PROPS  antecedent bit per property
cons  input  NUM_PROPS  consequent bit per property
fail_pulse  output  NUM_PROPS  registered one-cycle violation flag per property
fail_sticky  output  1  set on first violation, held until RESET/clear
fail_count  output  CNT_WIDTH  total violations, saturating at all-ones
first_fail_id  output  max(1,clog2(NUM_PROPS))  property index of first violation
first_fail_cycle  output  CYC_WIDTH  cycle_count value of the check cycle of first violation
cycle_count  output  CYC_WIDTH  cycles since RESET/clear deassertion, saturating

Behaviour:
- Reset: all outputs are 0 and all pending pipes are flushed, in the cycle after the RESET edge.
- Priority: RESET > clear > normal operation. clear has an identical effect to RESET.
- Cycle numbering: cycle 0 is the first cycle with RESET=0 and clear=0. cycle_count increments once per edge and holds at 2^CYC_WIDTH-1.
- Pending pipe per property:
  - DELAY-bit shift register; stage 0 loads (ante[p] & enable).
  - A bit entered at cycle t0 reaches the check point at cycle t0+DELAY.
- Check at cycle t: violation v[p] = pend_out[p] & ~cons[p].
  - cons is evaluated even when enable=0, so in-flight checks always complete.
- fail_pulse[p] = v[p] registered, i.e. high in cycle t+1 for exactly one cycle.
  - Antecedent at t0 → pulse at t0+DELAY+1 (total latency DELAY+1).
- fail_count:
  - Adds popcount(v) on each edge.
  - Sum is computed at CNT_WIDTH+clog2(NUM_PROPS)+1 bits, then clamped to 2^CNT_WIDTH-1.
  - Never wraps.
- First failure:
  - On the first edge with any v set while fail_sticky=0: capture first_fail_id = lowest set index of v, and first_fail_cycle = cycle_count at check cycle t.
  - fail_sticky goes to 1 together with the capture (visible in t+1).
  - Later violations do not alter the captured values.
- Overlapping antecedents (ante high on consecutive cycles): each is checked independently, with no merging.
- Simultaneous clear and violation in the same cycle: the violation is discarded and all state clears.
- RESET mid-flight: pending antecedents are dropped, and no pulse is emitted for them afterwards.
- enable falling while bits are pending: pending checks still fire; new antecedents are ignored.
- No combinational path from any input to any output.

Test Plan:
1. Reset with NUM_PROPS=2, DELAY=1: hold RESET 3 cycles, then release → all outputs 0; cycle_count reads 0,1,2,... in cycles 0,1,2.
2. Pass case: ante=01 in cycle 3, cons=01 in cycle 4 → fail_pulse stays 00, fail_count=0, fail_sticky=0.
3. Single violation: ante=01 in cycle 5, cons=00 in cycle 6 → in cycle 7: fail_pulse=01, fail_count=1, fail_sticky=1, first_fail_id=0, first_fail_cycle=6.
4. Simultaneous violations:
   - Setup: fresh after clear; ante=11 in cycle 2, cons=00 in cycle 3.
   - Response in cycle 4: fail_pulse=11, fail_count=2, first_fail_id=0, first_fail_cycle=3.
   - Follow-up: a later ante=10/cons=00 violation leaves first_fail_id at 0 and sets fail_count=3.
5. Saturation and DELAY:
   - Saturation, CNT_WIDTH=2: 5 separate violations → fail_count sequence 1,2,3,3,3.
   - DELAY=3: ante=01 in cycle 10 with cons=0 only in cycle 13 → fail_pulse=01 in cycle 14; cons=0 in cycles 11/12 produces no pulse.
6. Clear/reset interactions:
   - clear in the same cycle as a violating check → no pulse, fail_count=0, fail_sticky=0.
   - RESET asserted one cycle after ante=01 with DELAY=3 → no pulse ever appears for that antecedent.
   - enable=0 with ante=11 → never flagged.
